// File: rtl/bd_strobe_gen.sv
// Multi-channel programmable strobe generator with staged config and lock FSM.
// Optional output inversion field enabled by macro BD_STROBE_GEN_INV_EN.
module bd_strobe_gen #(
   parameter int NUM_CH   = 3,
   parameter int CNT_W    = 8,
   parameter int LOCK_CYC = 16
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              cfg_wr,
   input  logic [2:0]        cfg_ch,
   input  logic [1:0]        cfg_sel,
   input  logic [CNT_W-1:0]  cfg_data,
   input  logic              cfg_apply,
   output logic [NUM_CH-1:0] strb_out,
   output logic              cfg_busy,
   output logic              locked
);

   typedef enum logic {ST_SETTLE, ST_LOCKED} state_t;

   localparam logic [CNT_W-1:0] DEF_PER  = '1;
   localparam logic [CNT_W-1:0] DEF_HIGH = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [7:0]       SET_LAST = 8'(LOCK_CYC - 1);

   logic [CNT_W-1:0] r_stg_per  [NUM_CH];
   logic [CNT_W-1:0] r_stg_high [NUM_CH];
   logic [CNT_W-1:0] r_stg_ph   [NUM_CH];
   logic [CNT_W-1:0] r_act_per  [NUM_CH];
   logic [CNT_W-1:0] r_act_high [NUM_CH];
   logic [CNT_W-1:0] r_act_ph   [NUM_CH];
   logic [CNT_W-1:0] r_cnt      [NUM_CH];
   logic [CNT_W-1:0] w_nxt_per  [NUM_CH];
   logic [CNT_W-1:0] w_nxt_high [NUM_CH];
   logic [CNT_W-1:0] w_nxt_ph   [NUM_CH];
   logic [CNT_W-1:0] w_ld_new   [NUM_CH];
   logic [CNT_W-1:0] w_ld_act   [NUM_CH];
   logic [NUM_CH-1:0] r_strb;
   logic [NUM_CH-1:0] w_inv;
   logic              w_wr_ok;
   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_settle;
   logic [7:0]        w_settle_nxt;

`ifdef BD_STROBE_GEN_INV_EN
   logic [NUM_CH-1:0] r_stg_inv;
   logic [NUM_CH-1:0] r_act_inv;
   logic [NUM_CH-1:0] w_nxt_inv;
`endif

   assign w_wr_ok = cfg_wr && (int'(cfg_ch) < NUM_CH);

   // Staging view including a same-cycle write, so apply captures it
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_nxt_per[i]  = r_stg_per[i];
         w_nxt_high[i] = r_stg_high[i];
         w_nxt_ph[i]   = r_stg_ph[i];
      end
`ifdef BD_STROBE_GEN_INV_EN
      w_nxt_inv = r_stg_inv;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_wr_ok && (cfg_ch == 3'(i))) begin
            case (cfg_sel)
               2'd0:    w_nxt_per[i]  = cfg_data;
               2'd1:    w_nxt_high[i] = cfg_data;
               2'd2:    w_nxt_ph[i]   = cfg_data;
`ifdef BD_STROBE_GEN_INV_EN
               2'd3:    w_nxt_inv[i]  = cfg_data[0];
`endif
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_ld_new[i] = (w_nxt_ph[i] > w_nxt_per[i]) ? '0 : w_nxt_ph[i];
         w_ld_act[i] = (r_act_ph[i] > r_act_per[i]) ? '0 : r_act_ph[i];
      end
   end

`ifdef BD_STROBE_GEN_INV_EN
   assign w_inv = r_act_inv;
`else
   assign w_inv = '0;
`endif

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_stg_per[i]  <= DEF_PER;
            r_stg_high[i] <= DEF_HIGH;
            r_stg_ph[i]   <= '0;
            r_act_per[i]  <= DEF_PER;
            r_act_high[i] <= DEF_HIGH;
            r_act_ph[i]   <= '0;
         end
`ifdef BD_STROBE_GEN_INV_EN
         r_stg_inv <= '0;
         r_act_inv <= '0;
`endif
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_stg_per[i]  <= w_nxt_per[i];
            r_stg_high[i] <= w_nxt_high[i];
            r_stg_ph[i]   <= w_nxt_ph[i];
            if (cfg_apply) begin
               r_act_per[i]  <= w_nxt_per[i];
               r_act_high[i] <= w_nxt_high[i];
               r_act_ph[i]   <= w_nxt_ph[i];
            end
         end
`ifdef BD_STROBE_GEN_INV_EN
         r_stg_inv <= w_nxt_inv;
         if (cfg_apply) r_act_inv <= w_nxt_inv;
`endif
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
         r_strb <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_strb[i] <= (ch_en[i] && (r_cnt[i] < r_act_high[i])) ^ w_inv[i];
            if (cfg_apply)
               r_cnt[i] <= w_ld_new[i];
            else if (!ch_en[i])
               r_cnt[i] <= w_ld_act[i];
            else if (r_cnt[i] == r_act_per[i])
               r_cnt[i] <= '0;
            else
               r_cnt[i] <= r_cnt[i] + 1'b1;
         end
      end
   end

   assign strb_out = r_strb;

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_SETTLE;
         r_settle <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_settle <= w_settle_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_settle_nxt = r_settle;
      if (cfg_apply) begin
         w_state_nxt  = ST_SETTLE;
         w_settle_nxt = '0;
      end else if (r_state == ST_SETTLE) begin
         if (r_settle == SET_LAST) begin
            w_state_nxt  = ST_LOCKED;
            w_settle_nxt = '0;
         end else begin
            w_settle_nxt = r_settle + 8'd1;
         end
      end
   end

   assign locked   = (r_state == ST_LOCKED);
   assign cfg_busy = (r_state == ST_SETTLE);

endmodule
